alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: CLK  input  1  clock (rising edge); nRST  input  1  asynchronous active-low reset.
REQ-002 SHALL have, per requester i in {0,1}: req_valid_i  input  1  request present; req_ready_i  output  1  request accepted this cycle; req_op_i  input  aluop_t  ALU operation; req_a_i  input  32  operand A; req_b_i  input  32  operand B.
REQ-003 SHALL have, per requester i: rsp_valid_i  output  1  result available; rsp_ready_i  input  1  result consumed; rsp_out_i  output  32  ALU result; rsp_zero_i  output  1  result-is-zero flag.
REQ-004 SHALL have shared-ALU ports: alu_op  output  aluop_t  operation; alu_a  output  32  operand A; alu_b  output  32  operand B; alu_out  input  32  result; alu_zero  input  1  zero flag.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-006 SHALL implement FSM states IDLE, EXEC, RESP; single transaction in flight.
REQ-007 IDLE: SHALL assert req_ready_i only for the granted port, and only when its req_valid_i is high; no combinational path from req_ready_i to req_valid_i.
REQ-008 IDLE, handshake on port g: SHALL latch req_op_g, req_a_g, req_b_g and grant index g; next state EXEC.
REQ-009 EXEC (1 cycle): SHALL drive alu_op/alu_a/alu_b from latched values; capture alu_out and alu_zero at the clock edge; next state RESP.
REQ-010 RESP: SHALL assert rsp_valid_g only, with captured result held stable until rsp_ready_g; on rsp_valid_g & rsp_ready_g next state IDLE.
REQ-011 Latency: accept at edge N, rsp_valid at N+2; earliest next accept on the cycle after the response handshake.
REQ-012 rsp_out_i/rsp_zero_i of the non-granted port SHALL be 0; rsp_valid of the non-granted port SHALL be 0.
REQ-013 Outside EXEC SHALL drive alu_op = ALU_ADD, alu_a = 0, alu_b = 0.
REQ-014 Arbitration (IDLE only): single valid port wins; both valid: winner per REQ-020/021; neither valid: stay IDLE, no ready asserted.
REQ-015 Request inputs changing while not in IDLE SHALL be ignored; latched operands unaffected.
REQ-016 rsp_ready_i high while rsp_valid_i low SHALL have no effect.

Reset
REQ-017 nRST low SHALL immediately force: state IDLE, all req_ready_i = 0, all rsp_valid_i = 0, rsp_out_i = 0, rsp_zero_i = 0, latched operands = 0, grant index = 0, last-grant register = 1.
REQ-018 Reset in EXEC or RESP SHALL discard the in-flight transaction; no response is ever issued for it.
REQ-019 First acceptance SHALL be possible on the first rising edge after nRST deasserts.

Configuration
REQ-020 With ALU_ARB_RR_EN defined: SHALL use round-robin; on contention the port not granted last wins; last-grant register updates on each accepted request.
REQ-021 Without ALU_ARB_RR_EN: SHALL use fixed priority, port 0 always wins contention; last-grant register absent or unused.

Verification
REQ-022 Port 0 only: op=ALU_ADD, a=5, b=7 -> ready0 at accept edge, rsp_valid0=1 two cycles later with out=12, zero=0; port 1 outputs stay 0.
REQ-023 Port 1 only: op=ALU_SUB, a=9, b=9 -> rsp_valid1 with out=0, zero=1; held stable while rsp_ready1=0 for 5 cycles, then released to IDLE.
REQ-024 Both valid continuously, 4 transactions, RR build -> grants 0,1,0,1; fixed build -> grants 0,0,0,0 with port 1 starved.
REQ-025 Operands on port 0 altered during EXEC/RESP (a=1 -> a=100) -> result reflects original a=1 (op=ALU_SLL, b=4 -> out=16).
REQ-026 nRST asserted in RESP -> rsp_valid drops asynchronously, no response after release; next request (ALU_XOR, 0xF0, 0x0F) returns 0xFF.
REQ-027 Back-to-back: rsp_ready held high, req_valid0 held high -> one transaction per 3 cycles; alu_op=ALU_ADD, alu_a=alu_b=0 in all non-EXEC cycles.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: ALU operation type plus the requester/response/shared-ALU bundle
// between the two requesters, the arbiter and the external ALU.
package alu_arbiter_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA} aluop_t;
endpackage

interface alu_arbiter_if;
  import alu_arbiter_pkg::*;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero;
  aluop_t req_op [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [31:0] rsp_out [2];
  aluop_t alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic alu_zero;
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_zero,
    input  req_ready, rsp_valid, rsp_out, rsp_zero, alu_op, alu_a, alu_b
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_zero,
    output req_ready, rsp_valid, rsp_out, rsp_zero, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external ALU, one transaction in flight (IDLE/EXEC/RESP).
// Define ALU_ARB_RR_EN for round-robin contention; default is fixed priority to port 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input logic CLK,
  input logic nRST,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q;
  logic grant_q, zero_q, win, accept, exec;
  aluop_t op_q;
  logic [31:0] a_q, b_q, out_q;
`ifdef ALU_ARB_RR_EN
  logic last_q;
  assign win = &bus.req_valid ? ~last_q : bus.req_valid[1];
`else
  assign win = ~bus.req_valid[0];
`endif
  // ready is gated by reset so it drops immediately while nRST is low
  assign accept = nRST && state_q == IDLE && bus.req_valid[win];
  assign exec = state_q == EXEC;
  assign bus.req_ready = {accept & win, accept & ~win};
  assign bus.rsp_valid = {2{state_q == RESP}} & {grant_q, ~grant_q};
  assign bus.rsp_zero = bus.rsp_valid & {2{zero_q}};
  assign bus.rsp_out[0] = bus.rsp_valid[0] ? out_q : '0;
  assign bus.rsp_out[1] = bus.rsp_valid[1] ? out_q : '0;
  assign bus.alu_op = exec ? op_q : ALU_ADD;
  assign bus.alu_a = exec ? a_q : '0;
  assign bus.alu_b = exec ? b_q : '0;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      op_q <= ALU_ADD;
      a_q <= '0;
      b_q <= '0;
      out_q <= '0;
      zero_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= EXEC;
          grant_q <= win;
          op_q <= bus.req_op[win];
          a_q <= bus.req_a[win];
          b_q <= bus.req_b[win];
`ifdef ALU_ARB_RR_EN
          last_q <= win;
`endif
        end
        EXEC: begin
          state_q <= RESP;
          out_q <= bus.alu_out;
          zero_q <= bus.alu_zero;
        end
        RESP: if (bus.rsp_ready[grant_q]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic checked cycle by cycle against
// a transaction-level reference model; the bench also plays the external ALU.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  int checks = 0;
  int errors = 0;
  int obs_g [2];
  int m_phase = 0;
  bit m_g = 1'b0;
  bit m_last = 1'b1;
  aluop_t m_op = ALU_ADD;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  always #5 CLK = ~CLK;

  alu_arbiter_if bus ();
  alu_arbiter dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  function automatic logic [31:0] alu_fn(aluop_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return $unsigned($signed(a) >>> b[4:0]);
    endcase
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = bus.alu_out == 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.req_valid = 2'b11;
    nRST = 1'b0;
    #1;
    check("rst_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_out0", bus.rsp_out[0], 0);
    check("rst_out1", bus.rsp_out[1], 0);
    check("rst_zero", bus.rsp_zero, 2'b00);
    check("rst_alu_op", bus.alu_op, ALU_ADD);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    m_phase = 0;
    m_last = 1'b1;
    @(negedge CLK);
    bus.req_valid = 2'b00;
    nRST = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic cyc(input bit v0, input bit v1, input aluop_t o0, input aluop_t o1,
                     input logic [31:0] a0, input logic [31:0] b0,
                     input logic [31:0] a1, input logic [31:0] b1,
                     input bit r0, input bit r1);
    bit w;
    logic [1:0] er, ev;
    logic [31:0] res;
    bus.req_valid = {v1, v0};
    bus.req_op[0] = o0;
    bus.req_op[1] = o1;
    bus.req_a[0] = a0;
    bus.req_b[0] = b0;
    bus.req_a[1] = a1;
    bus.req_b[1] = b1;
    bus.rsp_ready = {r1, r0};
    #1;
    w = (v0 && v1) ? (RR ? ~m_last : 1'b0) : v1;
    er = (m_phase == 0 && (w ? v1 : v0)) ? (w ? 2'b10 : 2'b01) : 2'b00;
    ev = (m_phase == 2) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
    res = alu_fn(m_op, m_a, m_b);
    check("ready", bus.req_ready, er);
    check("rsp_valid", bus.rsp_valid, ev);
    check("rsp_out0", bus.rsp_out[0], ev[0] ? res : 32'd0);
    check("rsp_out1", bus.rsp_out[1], ev[1] ? res : 32'd0);
    check("rsp_zero", bus.rsp_zero, ev & {2{res == 32'd0}});
    check("alu_op", bus.alu_op, m_phase == 1 ? m_op : ALU_ADD);
    check("alu_a", bus.alu_a, m_phase == 1 ? m_a : 32'd0);
    check("alu_b", bus.alu_b, m_phase == 1 ? m_b : 32'd0);
    obs_g[0] += int'(bus.req_ready[0]);
    obs_g[1] += int'(bus.req_ready[1]);
    if (m_phase == 0 && er != 2'b00) begin
      m_phase = 1;
      m_g = w;
      m_last = w;
      m_op = w ? o1 : o0;
      m_a = w ? a1 : a0;
      m_b = w ? b1 : b0;
    end else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && (m_g ? r1 : r0)) m_phase = 0;
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 0, ALU_ADD, ALU_ADD, 0, 0, 0, 0, r, r);
  endtask

  initial begin
    int g1;
    bit v0, v1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    obs_g[0] = 0;
    obs_g[1] = 0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      bus.req_op[i] = ALU_ADD;
      bus.req_a[i] = '0;
      bus.req_b[i] = '0;
    end
    #2;
    do_reset();
    // port 0 ADD 5+7
    cyc(1, 0, ALU_ADD, ALU_ADD, 5, 7, 0, 0, 0, 0);
    idle(1, 0);
    #1;
    check("add_out", bus.rsp_out[0], 12);
    check("add_zero", bus.rsp_zero, 2'b00);
    check("add_out1", bus.rsp_out[1], 0);
    idle(2, 1);
    // port 1 SUB 9-9 held for 5 cycles
    cyc(0, 1, ALU_SUB, ALU_SUB, 0, 0, 9, 9, 0, 0);
    idle(6, 0);
    #1;
    check("sub_valid", bus.rsp_valid, 2'b10);
    check("sub_zero", bus.rsp_zero, 2'b10);
    idle(2, 1);
    // operand changes after acceptance are ignored
    cyc(1, 0, ALU_SLL, ALU_ADD, 1, 4, 0, 0, 0, 0);
    cyc(1, 0, ALU_SLL, ALU_ADD, 100, 4, 0, 0, 0, 0);
    #1;
    check("sll_out", bus.rsp_out[0], 16);
    cyc(1, 0, ALU_SLL, ALU_ADD, 100, 4, 0, 0, 0, 0);
    cyc(0, 0, ALU_SLL, ALU_ADD, 100, 4, 0, 0, 1, 1);
    idle(1, 1);
    // contention: four transactions
    g1 = obs_g[1];
    for (int i = 0; i < 12; i++) cyc(1, 1, ALU_ADD, ALU_OR, i, 1, i, 2, 1, 1);
    check("contention_g1", obs_g[1] - g1, RR ? 2 : 0);
    idle(1, 1);
    // back-to-back on port 0
    g1 = obs_g[0];
    for (int i = 0; i < 9; i++) cyc(1, 0, ALU_AND, ALU_ADD, 32'hFF, i, 0, 0, 1, 1);
    check("b2b_count", obs_g[0] - g1, 3);
    idle(1, 1);
    // reset while in RESP discards the transaction
    cyc(1, 0, ALU_ADD, ALU_ADD, 3, 4, 0, 0, 0, 0);
    idle(1, 0);
    do_reset();
    idle(3, 1);
    cyc(1, 0, ALU_XOR, ALU_ADD, 32'hF0, 32'h0F, 0, 0, 0, 0);
    idle(1, 0);
    #1;
    check("xor_out", bus.rsp_out[0], 32'hFF);
    idle(1, 1);
    for (int i = 0; i < 1500; i++) begin
      v0 = $urandom_range(0, 2) != 0;
      v1 = $urandom_range(0, 2) != 0;
      r0 = $urandom_range(0, 2) != 0;
      r1 = $urandom_range(0, 2) != 0;
      a0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7);
      b0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7);
      a1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7);
      b1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7);
      cyc(v0, v1, aluop_t'($urandom_range(0, 7)), aluop_t'($urandom_range(0, 7)),
          a0, b0, a1, b1, r0, r1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
